// File: rtl/colour_track_pkg.sv
// Shared types and constants for the colour blob tracker.
package colour_track_pkg;

  // Framing state: waiting for a start-of-frame pixel, or accumulating a frame.
  typedef enum logic [0:0] {
    StWaitSop,
    StInFrame
  } track_state_e;

  // Threshold field selectors for the configuration write port.
  localparam logic [2:0] FieldRMin = 3'd0;
  localparam logic [2:0] FieldRMax = 3'd1;
  localparam logic [2:0] FieldGMin = 3'd2;
  localparam logic [2:0] FieldGMax = 3'd3;
  localparam logic [2:0] FieldBMin = 3'd4;
  localparam logic [2:0] FieldBMax = 3'd5;
  localparam int unsigned NumFields = 6;

  // Class index width, including the extra "no match" code NUM_CLASSES.
  function automatic int unsigned cls_width(input int unsigned num_classes);
    return $clog2(num_classes + 1);
  endfunction

endpackage

// File: rtl/blob_accumulator.sv
// Per-class pixel count and bounding box for the current frame, plus the
// published result of the last completed frame.
module blob_accumulator #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,    // first pixel of a frame: drop prior state
  input  logic             hit,      // this pixel belongs to the class
  input  logic             publish,  // last pixel of a frame
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  output logic [CNT_W-1:0] res_count,
  output logic [X_W-1:0]   res_xmin,
  output logic [X_W-1:0]   res_xmax,
  output logic [Y_W-1:0]   res_ymin,
  output logic [Y_W-1:0]   res_ymax
);

  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_d;
  logic [X_W-1:0]   xmin_q, xmax_q, xmin_base, xmax_base, xmin_d, xmax_d;
  logic [Y_W-1:0]   ymin_q, ymax_q, ymin_base, ymax_base, ymin_d, ymax_d;

  // Fold the current pixel into the (possibly freshly cleared) accumulators.
  always_comb begin
    cnt_base  = start ? '0 : cnt_q;
    xmin_base = start ? '0 : xmin_q;
    xmax_base = start ? '0 : xmax_q;
    ymin_base = start ? '0 : ymin_q;
    ymax_base = start ? '0 : ymax_q;
    cnt_d  = cnt_base;
    xmin_d = xmin_base;
    xmax_d = xmax_base;
    ymin_d = ymin_base;
    ymax_d = ymax_base;
    if (hit) begin
      cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
      // Empty box: the first hit defines it; zero box doubles as "empty".
      if (cnt_base == '0) begin
        xmin_d = x;
        xmax_d = x;
        ymin_d = y;
        ymax_d = y;
      end else begin
        xmin_d = (x < xmin_base) ? x : xmin_base;
        xmax_d = (x > xmax_base) ? x : xmax_base;
        ymin_d = (y < ymin_base) ? y : ymin_base;
        ymax_d = (y > ymax_base) ? y : ymax_base;
      end
    end
  end

  // Accumulate, or on frame end publish and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      res_count <= '0;
      res_xmin  <= '0;
      res_xmax  <= '0;
      res_ymin  <= '0;
      res_ymax  <= '0;
    end else if (publish) begin
      res_count <= cnt_d;
      res_xmin  <= xmin_d;
      res_xmax  <= xmax_d;
      res_ymin  <= ymin_d;
      res_ymax  <= ymax_d;
      cnt_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

endmodule

// File: rtl/colour_blob_tracker.sv
// Streaming colour classifier with per-class blob counting and bounding boxes.
// One-cycle registered pixel path; frame statistics published on end of frame.
module colour_blob_tracker
  import colour_track_pkg::*;
#(
  parameter int unsigned PIXEL_W     = 4,
  parameter int unsigned NUM_CLASSES = 5,
  parameter int unsigned FRAME_W     = 640,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned CLS_W       = cls_width(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [PIXEL_W-1:0]     red_in,
  input  logic [PIXEL_W-1:0]     green_in,
  input  logic [PIXEL_W-1:0]     blue_in,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [2*PIXEL_W-1:0]   red_out,
  output logic [2*PIXEL_W-1:0]   green_out,
  output logic [2*PIXEL_W-1:0]   blue_out,
  output logic [CLS_W-1:0]       out_class,
  input  logic                   mask_en,
  input  logic                   cfg_we,
  input  logic [CLS_W-1:0]       cfg_class,
  input  logic [2:0]             cfg_field,
  input  logic [PIXEL_W-1:0]     cfg_data,
  input  logic                   cfg_en_we,
  input  logic [NUM_CLASSES-1:0] cfg_en,
  output logic                   res_valid,
  output logic                   frame_err,
  input  logic [CLS_W-1:0]       res_sel,
  output logic [CNT_W-1:0]       res_count,
  output logic [X_W-1:0]         res_xmin,
  output logic [X_W-1:0]         res_xmax,
  output logic [Y_W-1:0]         res_ymin,
  output logic [Y_W-1:0]         res_ymax,
  output logic                   res_found
);

  localparam logic [CLS_W-1:0] NoClass = CLS_W'(NUM_CLASSES);
  localparam logic [X_W-1:0]   XLast   = X_W'(FRAME_W - 1);

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  logic [PIXEL_W-1:0]     thr_q [NUM_CLASSES][NumFields];
  logic [NUM_CLASSES-1:0] en_q;

  // Threshold and enable registers; mins reset high and maxes low so nothing matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        for (int f = 0; f < NumFields; f++) begin
          if (f % 2 == 0) thr_q[k][f] <= '1;
          else            thr_q[k][f] <= '0;
        end
      end
    end else begin
      if (cfg_en_we) en_q <= cfg_en;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        for (int f = 0; f < NumFields; f++) begin
          if (cfg_we && cfg_class == CLS_W'(k) && cfg_field == 3'(f)) thr_q[k][f] <= cfg_data;
        end
      end
    end
  end

  logic [NUM_CLASSES-1:0] class_hit;
  logic [CLS_W-1:0]       match_class;

  // Box test per class; walking down from the top leaves the lowest index winning.
  always_comb begin
    class_hit   = '0;
    match_class = NoClass;
    for (int k = int'(NUM_CLASSES) - 1; k >= 0; k--) begin
      class_hit[k] = en_q[k] &&
                     red_in   >= thr_q[k][FieldRMin] && red_in   <= thr_q[k][FieldRMax] &&
                     green_in >= thr_q[k][FieldGMin] && green_in <= thr_q[k][FieldGMax] &&
                     blue_in  >= thr_q[k][FieldBMin] && blue_in  <= thr_q[k][FieldBMax];
      if (class_hit[k]) match_class = CLS_W'(k);
    end
  end

  // Output pixel register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      out_class <= NoClass;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
      out_class <= match_class;
      if (mask_en && match_class == NoClass) begin
        red_out   <= '0;
        green_out <= '0;
        blue_out  <= '0;
      end else begin
        red_out   <= {red_in, red_in};
        green_out <= {green_in, green_in};
        blue_out  <= {blue_in, blue_in};
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  track_state_e   state_q;
  logic [X_W-1:0] x_q, cur_x;
  logic [Y_W-1:0] y_q, cur_y;
  logic           track, start, publish;

  // A sop pixel always sits at (0,0) and restarts accumulation.
  always_comb begin
    start   = accept && in_sop;
    track   = accept && (in_sop || state_q == StInFrame);
    publish = track && in_eop;
    cur_x   = in_sop ? '0 : x_q;
    cur_y   = in_sop ? '0 : y_q;
  end

  // Framing FSM with raster position, result strobe and sticky framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWaitSop;
      x_q       <= '0;
      y_q       <= '0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      res_valid <= publish;
      if (start && state_q == StInFrame) frame_err <= 1'b1;
      if (accept && in_eop && !in_sop && state_q == StWaitSop) frame_err <= 1'b1;
      if (track) begin
        state_q <= in_eop ? StWaitSop : StInFrame;
        if (cur_x == XLast) begin
          x_q <= '0;
          y_q <= (cur_y == '1) ? cur_y : cur_y + 1'b1;
        end else begin
          x_q <= cur_x + 1'b1;
          y_q <= cur_y;
        end
      end
    end
  end

  logic [CNT_W-1:0] acc_count [NUM_CLASSES];
  logic [X_W-1:0]   acc_xmin  [NUM_CLASSES];
  logic [X_W-1:0]   acc_xmax  [NUM_CLASSES];
  logic [Y_W-1:0]   acc_ymin  [NUM_CLASSES];
  logic [Y_W-1:0]   acc_ymax  [NUM_CLASSES];

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_acc
    blob_accumulator #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .CNT_W (CNT_W)
    ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .hit       (track && match_class == CLS_W'(k)),
      .publish   (publish),
      .x         (cur_x),
      .y         (cur_y),
      .res_count (acc_count[k]),
      .res_xmin  (acc_xmin[k]),
      .res_xmax  (acc_xmax[k]),
      .res_ymin  (acc_ymin[k]),
      .res_ymax  (acc_ymax[k])
    );
  end

  // Result readback; out-of-range selects read as zero.
  always_comb begin
    res_count = '0;
    res_xmin  = '0;
    res_xmax  = '0;
    res_ymin  = '0;
    res_ymax  = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (res_sel == CLS_W'(k)) begin
        res_count = acc_count[k];
        res_xmin  = acc_xmin[k];
        res_xmax  = acc_xmax[k];
        res_ymin  = acc_ymin[k];
        res_ymax  = acc_ymax[k];
      end
    end
    res_found = (res_count != '0);
  end

endmodule

// File: tb/tb_colour_blob_tracker.sv
// Directed bench for colour_blob_tracker: 4-pixel lines, 2-bit counters.
module tb_colour_blob_tracker;

  localparam int unsigned PIXEL_W     = 4;
  localparam int unsigned NUM_CLASSES = 5;
  localparam int unsigned FRAME_W     = 4;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned CLS_W       = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_ready;
  logic [PIXEL_W-1:0] red_in = '0, green_in = '0, blue_in = '0;
  logic out_valid, out_ready = 1'b1, out_sop, out_eop;
  logic [2*PIXEL_W-1:0] red_out, green_out, blue_out;
  logic [CLS_W-1:0] out_class;
  logic mask_en = 1'b1;
  logic cfg_we = 1'b0;
  logic [CLS_W-1:0] cfg_class = '0;
  logic [2:0] cfg_field = '0;
  logic [PIXEL_W-1:0] cfg_data = '0;
  logic cfg_en_we = 1'b0;
  logic [NUM_CLASSES-1:0] cfg_en = '0;
  logic res_valid, frame_err, res_found;
  logic [CLS_W-1:0] res_sel = '0;
  logic [CNT_W-1:0] res_count;
  logic [X_W-1:0] res_xmin, res_xmax;
  logic [Y_W-1:0] res_ymin, res_ymax;

  int n_vec = 0;
  int n_err = 0;
  int rv_cnt = 0;
  int rv0;

  always #5 clk = ~clk;

  always @(posedge clk) if (res_valid) rv_cnt++;

  colour_blob_tracker #(
    .PIXEL_W     (PIXEL_W),
    .NUM_CLASSES (NUM_CLASSES),
    .FRAME_W     (FRAME_W),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .red_out   (red_out),
    .green_out (green_out),
    .blue_out  (blue_out),
    .out_class (out_class),
    .mask_en   (mask_en),
    .cfg_we    (cfg_we),
    .cfg_class (cfg_class),
    .cfg_field (cfg_field),
    .cfg_data  (cfg_data),
    .cfg_en_we (cfg_en_we),
    .cfg_en    (cfg_en),
    .res_valid (res_valid),
    .frame_err (frame_err),
    .res_sel   (res_sel),
    .res_count (res_count),
    .res_xmin  (res_xmin),
    .res_xmax  (res_xmax),
    .res_ymin  (res_ymin),
    .res_ymax  (res_ymax),
    .res_found (res_found)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                      input logic sop, input logic eop);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    in_sop   = sop;
    in_eop   = eop;
    t = 0;
    while (!in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic check_pix(input string tag, input logic [2:0] cls,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_class"}, 32'(out_class), 32'(cls));
    check({tag, "_red"}, 32'(red_out), 32'(r));
    check({tag, "_green"}, 32'(green_out), 32'(g));
    check({tag, "_blue"}, 32'(blue_out), 32'(b));
  endtask

  task automatic check_res(input string tag, input logic [2:0] sel, input int cnt,
                           input int xmin, input int xmax, input int ymin, input int ymax,
                           input logic found);
    @(negedge clk);
    res_sel = sel;
    #1;
    check({tag, "_count"}, 32'(res_count), 32'(cnt));
    check({tag, "_xmin"}, 32'(res_xmin), 32'(xmin));
    check({tag, "_xmax"}, 32'(res_xmax), 32'(xmax));
    check({tag, "_ymin"}, 32'(res_ymin), 32'(ymin));
    check({tag, "_ymax"}, 32'(res_ymax), 32'(ymax));
    check({tag, "_found"}, 32'(res_found), 32'(found));
  endtask

  task automatic cfg_write(input logic [2:0] cls, input logic [2:0] fld, input logic [3:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_class = cls;
    cfg_field = fld;
    cfg_data  = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Class 0: R8..15 G2..5 B0..5. Class 1: exactly (10,3,2).
  task automatic program_classes();
    cfg_write(3'd0, 3'd0, 4'd8);
    cfg_write(3'd0, 3'd1, 4'd15);
    cfg_write(3'd0, 3'd2, 4'd2);
    cfg_write(3'd0, 3'd3, 4'd5);
    cfg_write(3'd0, 3'd4, 4'd0);
    cfg_write(3'd0, 3'd5, 4'd5);
    cfg_write(3'd1, 3'd0, 4'd10);
    cfg_write(3'd1, 3'd1, 4'd10);
    cfg_write(3'd1, 3'd2, 4'd3);
    cfg_write(3'd1, 3'd3, 4'd3);
    cfg_write(3'd1, 3'd4, 4'd2);
    cfg_write(3'd1, 3'd5, 4'd2);
    @(negedge clk);
    cfg_en_we = 1'b1;
    cfg_en    = 5'b00011;
    @(negedge clk);
    cfg_en_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stall the consumer for 3 cycles; the last accepted pixel was a class-0 (10,3,2).
  task automatic stall_check();
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_class", 32'(out_class), 32'd0);
      check("stall_red_out", 32'(red_out), 32'hAA);
    end
    out_ready = 1'b1;
  endtask

  // Pixel i sits at (i%4, i/4); hits[i] selects (10,3,2), otherwise (1,1,1).
  task automatic run_frame(input int n, input logic [15:0] hits, input logic with_eop,
                           input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) stall_check();
      if (hits[i]) send(4'd10, 4'd3, 4'd2, i == 0, with_eop && (i == n - 1));
      else         send(4'd1, 4'd1, 4'd1, i == 0, with_eop && (i == n - 1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd5);
    check("rst_red_out", 32'(red_out), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Nothing enabled after reset
    send(4'd10, 4'd3, 4'd2, 1'b0, 1'b0);
    check_pix("disabled", 3'd5, 8'h00, 8'h00, 8'h00);

    program_classes();
    send(4'd10, 4'd3, 4'd2, 1'b0, 1'b0);
    check_pix("prio_c0", 3'd0, 8'hAA, 8'h33, 8'h22);
    send(4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
    check_pix("nomatch_mask", 3'd5, 8'h00, 8'h00, 8'h00);
    mask_en = 1'b0;
    send(4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
    check_pix("nomatch_pass", 3'd5, 8'h11, 8'h11, 8'h11);
    mask_en = 1'b1;
    send(4'd15, 4'd5, 4'd5, 1'b0, 1'b0);
    check_pix("upper_edge", 3'd0, 8'hFF, 8'h55, 8'h55);
    send(4'd8, 4'd2, 4'd0, 1'b0, 1'b0);
    check_pix("lower_edge", 3'd0, 8'h88, 8'h22, 8'h00);
    send(4'd7, 4'd3, 4'd2, 1'b0, 1'b0);
    check_pix("r_below", 3'd5, 8'h00, 8'h00, 8'h00);
    send(4'd8, 4'd6, 4'd0, 1'b0, 1'b0);
    check_pix("g_above", 3'd5, 8'h00, 8'h00, 8'h00);
    check("passthru_frame_err", 32'(frame_err), 32'd0);
    check("passthru_res_valid_cnt", 32'(rv_cnt), 32'd0);

    // 16-pixel frame, class-0 hits at (1,1) and (2,3)
    rv0 = rv_cnt;
    run_frame(16, 16'h4020, 1'b1, -1);
    repeat (2) @(negedge clk);
    check("frame_res_valid", 32'(rv_cnt - rv0), 32'd1);
    check_res("frame_c0", 3'd0, 2, 1, 2, 1, 3, 1'b1);
    check_res("frame_c2", 3'd2, 0, 0, 0, 0, 0, 1'b0);
    check_res("frame_sel7", 3'd7, 0, 0, 0, 0, 0, 1'b0);
    check("frame_err_clean", 32'(frame_err), 32'd0);

    // Same frame with a 3-cycle consumer stall after pixel 5
    rv0 = rv_cnt;
    run_frame(16, 16'h4020, 1'b1, 6);
    repeat (2) @(negedge clk);
    check("stall_res_valid", 32'(rv_cnt - rv0), 32'd1);
    check_res("stall_c0", 3'd0, 2, 1, 2, 1, 3, 1'b1);

    // eop outside a frame: error only, results untouched
    rv0 = rv_cnt;
    send(4'd10, 4'd3, 4'd2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("stray_eop_err", 32'(frame_err), 32'd1);
    check("stray_eop_res_valid", 32'(rv_cnt - rv0), 32'd0);
    check_res("stray_eop_c0", 3'd0, 2, 1, 2, 1, 3, 1'b1);

    // Reset clears error, results and configuration
    do_reset();
    #1;
    check("reset2_frame_err", 32'(frame_err), 32'd0);
    check_res("reset2_c0", 3'd0, 0, 0, 0, 0, 0, 1'b0);
    program_classes();

    // sop at pixel 5: partial frame (hit at (1,0)) discarded, restarted frame hit at (2,3)
    rv0 = rv_cnt;
    run_frame(5, 16'h0002, 1'b0, -1);
    check("partial_res_valid", 32'(rv_cnt - rv0), 32'd0);
    check("partial_err", 32'(frame_err), 32'd0);
    run_frame(16, 16'h4000, 1'b1, -1);
    repeat (2) @(negedge clk);
    check("restart_err", 32'(frame_err), 32'd1);
    check("restart_res_valid", 32'(rv_cnt - rv0), 32'd1);
    check_res("restart_c0", 3'd0, 1, 2, 2, 3, 3, 1'b1);

    // Reset mid-frame, then a fresh frame with 5 hits into a 2-bit counter
    rv0 = rv_cnt;
    run_frame(4, 16'h0007, 1'b0, -1);
    do_reset();
    repeat (3) @(negedge clk);
    check("midreset_res_valid", 32'(rv_cnt - rv0), 32'd0);
    check_res("midreset_c0", 3'd0, 0, 0, 0, 0, 0, 1'b0);
    program_classes();
    rv0 = rv_cnt;
    run_frame(16, 16'h1249, 1'b1, -1);
    repeat (2) @(negedge clk);
    check("sat_res_valid", 32'(rv_cnt - rv0), 32'd1);
    check_res("sat_c0", 3'd0, 3, 0, 3, 0, 3, 1'b1);

    // Single-pixel frame
    rv0 = rv_cnt;
    send(4'd10, 4'd3, 4'd2, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("single_res_valid", 32'(rv_cnt - rv0), 32'd1);
    check_res("single_c0", 3'd0, 1, 0, 0, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/colour_blob_tracker.md
COLOUR_BLOB_TRACKER -- requirements
Module: colour_blob_tracker

Interface
REQ-001 Parameter PIXEL_W, default 4: bits per colour channel in.
REQ-002 Parameter NUM_CLASSES, default 5: number of programmable colour classes.
REQ-003 Parameter FRAME_W, default 640: pixels per line.
REQ-004 Parameters X_W, Y_W, CNT_W, defaults 10, 9, 19: coordinate and counter widths.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid, in_sop, in_eop  in  1 each  pixel qualifier, first pixel of frame, last pixel of frame.
REQ-008 red_in, green_in, blue_in  in  PIXEL_W each  input pixel; in_ready  out  1  pixel accepted when in_valid&&in_ready.
REQ-009 out_valid  out  1; out_ready  in  1; out_sop, out_eop  out  1 each.
REQ-010 red_out, green_out, blue_out  out  2*PIXEL_W each  {ch,ch} replicated pixel; out_class  out  CLS_W  matched class, NUM_CLASSES = none.
REQ-011 mask_en  in  1  1: black out unmatched pixels; 0: pass all pixels.
REQ-012 cfg_we  in  1; cfg_class  in  CLS_W; cfg_field  in  3; cfg_data  in  PIXEL_W  threshold write port.
REQ-013 cfg_en_we  in  1; cfg_en  in  NUM_CLASSES  class-enable write.
REQ-014 res_valid  out  1  one-cycle pulse, frame results updated; frame_err  out  1  sticky.
REQ-015 res_sel  in  CLS_W; res_count  out  CNT_W; res_xmin, res_xmax  out  X_W; res_ymin, res_ymax  out  Y_W; res_found  out  1.

Function
REQ-016 Class k SHALL match when enabled and Rmin<=R<=Rmax, Gmin<=G<=Gmax, Bmin<=B<=Bmax (unsigned, inclusive); cfg_field 0..5 = Rmin,Rmax,Gmin,Gmax,Bmin,Bmax.
REQ-017 Multiple matches: lowest class index SHALL win; no match: out_class = NUM_CLASSES.
REQ-018 Stream latency SHALL be exactly 1 accepted cycle; in_ready = !out_valid || out_ready; outputs held stable while out_valid && !out_ready.
REQ-019 mask_en=1 and no match: colour outputs SHALL be 0; otherwise replicated input.
REQ-020 cfg writes SHALL affect pixels accepted on the cycle after the write; cfg_class >= NUM_CLASSES ignored.
REQ-021 FSM states WAIT_SOP, IN_FRAME; accepted in_sop -> IN_FRAME with x=0, y=0 for that pixel; pixels accepted in WAIT_SOP without sop SHALL pass through but not accumulate.
REQ-022 x SHALL increment per accepted pixel, wrap FRAME_W-1 -> 0 with y+1; y saturates at all-ones.
REQ-023 Per matched pixel of class k: count_k +1 saturating at 2^CNT_W-1; bounding box min/max update.
REQ-024 Accepted in_eop in IN_FRAME: accumulators SHALL copy to result registers, res_valid pulses next cycle, accumulators clear, FSM -> WAIT_SOP.
REQ-025 sop && eop same pixel: single-pixel frame, results published.
REQ-026 sop while IN_FRAME: partial frame discarded, no res_valid, frame_err set, accumulation restarts with that pixel.
REQ-027 eop in WAIT_SOP SHALL be ignored for accumulation and set frame_err.
REQ-028 res_found = (count of res_sel class != 0); count 0 reports box xmin=ymin=0, xmax=ymax=0; res_sel >= NUM_CLASSES returns all zeros.

Reset
REQ-029 rst_n low SHALL clear out_valid, out_sop, out_eop, colour outputs, res_valid, frame_err, all counters and results; out_class = NUM_CLASSES; FSM = WAIT_SOP.
REQ-030 Reset SHALL set all class enables 0, min thresholds all-ones, max thresholds 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no res_valid after release.

Structure
REQ-032 Package colour_track_pkg SHALL hold FSM state enum, cfg_field encodings, and CLS_W = $clog2(NUM_CLASSES+1) helper.
REQ-033 Sub-module blob_accumulator SHALL implement one class's count and bounding box, instantiated NUM_CLASSES times.

Verification
REQ-034 Class0 R8..15 G2..5 B0..5 enabled, pixel (10,3,2), mask_en=1 -> next cycle out_class 0, red_out 8'hAA, green_out 8'h33, blue_out 8'h22.
REQ-035 Classes 0 and 1 both matching pixel -> out_class 0; unmatched pixel with mask_en=1 -> all colour 0, out_class 5.
REQ-036 FRAME_W=4, 16-pixel frame, class-0 pixels at (1,1),(2,3) -> res_valid once, count 2, box x1..2 y1..3, res_found 1.
REQ-037 out_ready held 0 for 3 cycles mid-frame -> in_ready 0, outputs stable, no pixel lost, results unchanged vs. unstalled run.
REQ-038 sop at pixel 5 of a frame -> frame_err 1, no res_valid, results from the restarted frame only.
REQ-039 rst_n asserted mid-frame then released, new frame -> results reflect only the new frame; CNT_W=2 with 5 matches -> count 3.
